// File: rtl/acc_seq_if.sv
// acc_seq_if: operand-in and result-out valid/ready streams of the accumulator sequencer
interface acc_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             out_ready;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_ovf);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_ovf);
endinterface

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: sums groups of cfg_len operands, emits one result per group, cfg_groups groups per job
module acc_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16,
  parameter int GRP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [GRP_W-1:0] cfg_groups,
  output logic             busy,
  output logic             done,
  acc_seq_if.slave         s
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;
  logic [1:0]       state;
  logic [LEN_W-1:0] len, cnt;
  logic [GRP_W-1:0] groups, grp;
  logic [WIDTH-1:0] sum, res;
  logic             ovf, res_ovf;
  logic [WIDTH:0]   add_w;
  logic             last_op, last_grp;
  assign add_w       = {1'b0, sum} + {1'b0, s.in_data};
  assign last_op     = cnt == len - LEN_W'(1);
  assign last_grp    = grp == groups - GRP_W'(1);
  assign busy        = state != IDLE;
  assign s.in_ready  = state == ACC;
  assign s.out_valid = state == OUT;
  assign s.out_data  = res;
  assign s.out_ovf   = res_ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      len     <= '0;
      groups  <= '0;
      cnt     <= '0;
      grp     <= '0;
      sum     <= '0;
      ovf     <= 1'b0;
      res     <= '0;
      res_ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        if (cfg_len != '0 && cfg_groups != '0) begin
          len    <= cfg_len;
          groups <= cfg_groups;
          sum    <= '0;
          ovf    <= 1'b0;
          cnt    <= '0;
          grp    <= '0;
          state  <= ACC;
        end else begin
          done <= 1'b1;
        end
      end
      if (state == ACC && s.in_valid) begin
        if (last_op) begin
          res     <= add_w[WIDTH-1:0];
          res_ovf <= ovf | add_w[WIDTH];
          state   <= OUT;
        end else begin
          sum <= add_w[WIDTH-1:0];
          ovf <= ovf | add_w[WIDTH];
          cnt <= cnt + LEN_W'(1);
        end
      end
      if (state == OUT && s.out_ready) begin
        if (last_grp) begin
          state <= IDLE;
          done  <= 1'b1;
        end else begin
          grp   <= grp + GRP_W'(1);
          sum   <= '0;
          cnt   <= '0;
          ovf   <= 1'b0;
          state <= ACC;
        end
      end
    end
  end
endmodule

// File: tb/tb_acc_seq_ctrl.sv
// tb_acc_seq_ctrl: directed scenario tasks for acc_seq_ctrl with hand-computed expectations
module tb_acc_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [15:0] cfg_groups = '0;
  logic        busy, done;
  int          vecs = 0;
  int          errs = 0;
  acc_seq_if #(.WIDTH(32)) ifc();
  acc_seq_ctrl #(.WIDTH(32), .LEN_W(16), .GRP_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_groups(cfg_groups),
    .busy(busy), .done(done), .s(ifc.slave)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] l, input logic [15:0] g);
    cfg_len = l;
    cfg_groups = g;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input string name);
    int n = 0;
    while (!ifc.in_ready && n < 20) begin
      tick();
      n++;
    end
    vecs++;
    if (ifc.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL %s in_ready timeout got %b exp 1", name, ifc.in_ready);
    end
    ifc.in_valid = 1'b1;
    ifc.in_data = d;
    tick();
    ifc.in_valid = 1'b0;
  endtask

  task automatic recv(input logic [31:0] exp_d, input logic exp_o, input int stall, input logic exp_done, input string name);
    int n = 0;
    while (!ifc.out_valid && n < 20) begin
      tick();
      n++;
    end
    vecs++;
    if (ifc.out_valid !== 1'b1) begin
      errs++;
      $display("FAIL %s out_valid timeout got %b exp 1", name, ifc.out_valid);
    end
    vecs++;
    if (ifc.out_data !== exp_d || ifc.out_ovf !== exp_o) begin
      errs++;
      $display("FAIL %s result got %h/%b exp %h/%b", name, ifc.out_data, ifc.out_ovf, exp_d, exp_o);
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      vecs++;
      if (ifc.out_valid !== 1'b1 || ifc.out_data !== exp_d || ifc.out_ovf !== exp_o || ifc.in_ready !== 1'b0) begin
        errs++;
        $display("FAIL %s stall%0d got v=%b d=%h o=%b rdy=%b exp v=1 d=%h o=%b rdy=0", name, i,
                 ifc.out_valid, ifc.out_data, ifc.out_ovf, ifc.in_ready, exp_d, exp_o);
      end
    end
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    vecs++;
    if (done !== exp_done || busy !== !exp_done) begin
      errs++;
      $display("FAIL %s after handshake got done=%b busy=%b exp done=%b busy=%b", name, done, busy, exp_done, !exp_done);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({busy, done, ifc.in_ready, ifc.out_valid, ifc.out_ovf} !== 5'b0 || ifc.out_data !== 32'd0) begin
      errs++;
      $display("FAIL reset got b=%b d=%b ir=%b ov=%b of=%b od=%h exp all 0", busy, done, ifc.in_ready,
               ifc.out_valid, ifc.out_ovf, ifc.out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    go(16'd4, 16'd1);
    vecs++;
    if (busy !== 1'b1 || ifc.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL basic_start got busy=%b in_ready=%b exp 1/1", busy, ifc.in_ready);
    end
    for (int i = 1; i <= 4; i++) send(32'(i), "basic_in");
    vecs++;
    if (ifc.out_valid !== 1'b1 || ifc.out_data !== 32'd10 || ifc.out_ovf !== 1'b0) begin
      errs++;
      $display("FAIL basic_latency got v=%b d=%h o=%b exp 1/0000000a/0", ifc.out_valid, ifc.out_data, ifc.out_ovf);
    end
    recv(32'd10, 1'b0, 0, 1'b1, "basic_out");
    tick();
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_done_pulse got done=%b busy=%b exp 0/0", done, busy);
    end
  endtask

  task automatic test_stall();
    go(16'd2, 16'd3);
    send(32'd5, "stall_in");
    send(32'd6, "stall_in");
    recv(32'd11, 1'b0, 3, 1'b0, "stall_r0");
    send(32'd7, "stall_in");
    send(32'd8, "stall_in");
    recv(32'd15, 1'b0, 3, 1'b0, "stall_r1");
    send(32'd9, "stall_in");
    send(32'd10, "stall_in");
    recv(32'd19, 1'b0, 3, 1'b1, "stall_r2");
    tick();
    vecs++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL stall_single_done got %b exp 0", done);
    end
  endtask

  task automatic test_ovf();
    go(16'd2, 16'd2);
    send(32'hFFFF_FFFF, "ovf_in");
    send(32'h0000_0002, "ovf_in");
    recv(32'h0000_0001, 1'b1, 0, 1'b0, "ovf_carry");
    send(32'd1, "ovf_in");
    send(32'd1, "ovf_in");
    recv(32'd2, 1'b0, 0, 1'b1, "ovf_cleared");
  endtask

  task automatic test_zero_cfg();
    logic [1:0] lg [2] = '{2'b01, 2'b10};
    for (int k = 0; k < 2; k++) begin
      go(lg[k][0] ? 16'd0 : 16'd3, lg[k][1] ? 16'd0 : 16'd3);
      vecs++;
      if (done !== 1'b1 || busy !== 1'b0 || ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0) begin
        errs++;
        $display("FAIL zero_cfg%0d got done=%b busy=%b ir=%b ov=%b exp 1/0/0/0", k, done, busy, ifc.in_ready, ifc.out_valid);
      end
      tick();
      vecs++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL zero_cfg%0d_pulse got done=%b busy=%b exp 0/0", k, done, busy);
      end
    end
  endtask

  task automatic test_busy_start();
    go(16'd2, 16'd1);
    send(32'd5, "busy_in");
    go(16'd1, 16'd1);
    vecs++;
    if (ifc.out_valid !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL busy_start_ignored got ov=%b busy=%b exp 0/1", ifc.out_valid, busy);
    end
    send(32'd6, "busy_in");
    recv(32'd11, 1'b0, 0, 1'b1, "busy_result");
  endtask

  task automatic test_gaps();
    go(16'd1, 16'd5);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(32'(i * 17 + 3), "gap_in");
      recv(32'(i * 17 + 3), 1'b0, 0, i == 4, "gap_out");
    end
    repeat (3) tick();
    vecs++;
    if (ifc.out_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL gap_no_extra got ov=%b busy=%b exp 0/0", ifc.out_valid, busy);
    end
  endtask

  task automatic test_abort();
    go(16'd4, 16'd1);
    send(32'd100, "abort_in");
    send(32'd200, "abort_in");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL abort_state got busy=%b done=%b ir=%b ov=%b exp 0/0/0/0", busy, done, ifc.in_ready, ifc.out_valid);
    end
    tick();
    vecs++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL abort_no_done got %b exp 0", done);
    end
    go(16'd2, 16'd1);
    send(32'd3, "abort_in");
    send(32'd4, "abort_in");
    recv(32'd7, 1'b0, 0, 1'b1, "abort_fresh");
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_data = '0;
    ifc.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_ovf();
    test_zero_cfg();
    test_busy_start();
    test_gaps();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
